// File: rtl/lockin_noise_pkg.sv
// Shared widths, saturation limits and sample conversion for the lock-in noise path.
package lockin_noise_pkg;

  function automatic int sum_w(int in_bits, int sum_log2);
    return in_bits + sum_log2;
  endfunction

  function automatic int prod_w(int sum_bits, int gain_bits);
    return sum_bits + gain_bits + 1;
  endfunction

  function automatic longint sat_max(int out_bits);
    return (longint'(1) <<< (out_bits - 1)) - 1;
  endfunction

  function automatic longint sat_min(int out_bits);
    return -(longint'(1) <<< (out_bits - 1));
  endfunction

  // Offset-binary to two's complement is just an MSB flip.
  function automatic logic [63:0] ob_to_signed(logic [63:0] d, int in_bits);
    return d ^ (64'd1 << (in_bits - 1));
  endfunction

endpackage

// File: rtl/noise_sat_add.sv
// Signed add of a wide value and a narrow offset, clamped to the narrow width.
module noise_sat_add
  import lockin_noise_pkg::*;
#(
  parameter int IN_W  = 29,
  parameter int OUT_W = 16
) (
  input  logic signed [IN_W-1:0]  i_a,
  input  logic signed [OUT_W-1:0] i_b,
  output logic signed [OUT_W-1:0] o_y,
  output logic                    o_sat
);

  localparam int SW = IN_W + 1;
  localparam logic signed [SW-1:0] MAX_V = SW'(sat_max(OUT_W));
  localparam logic signed [SW-1:0] MIN_V = SW'(sat_min(OUT_W));

  logic signed [SW-1:0] sum;

  always_comb begin
    sum   = SW'(i_a) + SW'(i_b);
    o_y   = sum[OUT_W-1:0];
    o_sat = 1'b0;
    if (sum > MAX_V) begin
      o_y   = MAX_V[OUT_W-1:0];
      o_sat = 1'b1;
    end else if (sum < MIN_V) begin
      o_y   = MIN_V[OUT_W-1:0];
      o_sat = 1'b1;
    end
  end

endmodule

// File: rtl/lfsr_noise_shaper.sv
// Sums 2^SUM_LOG2 LFSR words into near-Gaussian noise, then gain, offset and clamp
// in a three-edge pipeline with a one-cycle valid pulse per block.
module lfsr_noise_shaper
  import lockin_noise_pkg::*;
#(
  parameter int IN_BITS   = 16,
  parameter int SUM_LOG2  = 4,
  parameter int GAIN_BITS = 8,
  parameter int OUT_BITS  = 16
) (
  input  logic                       i_Clk,
  input  logic                       i_Reset,
  input  logic                       i_Enable,
  input  logic                       i_Clear,
  input  logic [IN_BITS-1:0]         i_LFSR_Data,
  input  logic                       i_LFSR_valid,
  input  logic [GAIN_BITS-1:0]       i_Gain,
  input  logic signed [OUT_BITS-1:0] i_Offset,
  output logic signed [OUT_BITS-1:0] o_Noise,
  output logic                       o_Noise_valid,
  output logic                       o_Sat,
  output logic                       o_Sat_sticky,
  output logic [SUM_LOG2-1:0]        o_Count
);

  localparam int SUM_W = sum_w(IN_BITS, SUM_LOG2);
  localparam int PROD_W = prod_w(SUM_W, GAIN_BITS);
  // Gain full scale ~1.0, and dividing by sqrt(N) keeps the noise sigma independent of N.
  localparam int SHIFT = GAIN_BITS + SUM_LOG2 / 2;
  localparam logic [SUM_LOG2-1:0] CNT_MAX = {SUM_LOG2{1'b1}};

  logic signed [SUM_W-1:0]    acc_q, acc_d, sum_q, sum_d;
  logic [SUM_LOG2-1:0]        cnt_q, cnt_d;
  logic                       sum_v_q, sum_v_d, prod_v_q, prod_v_d;
  logic signed [PROD_W-1:0]   prod_q, prod_d;
  logic signed [OUT_BITS-1:0] noise_q, noise_d;
  logic                       noise_v_q, noise_v_d, sat_q, sat_d, sticky_q, sticky_d;

  logic signed [IN_BITS-1:0]  samp;
  logic signed [SUM_W-1:0]    samp_ext;
  logic signed [PROD_W-1:0]   prod_full;
  logic signed [OUT_BITS-1:0] sat_y;
  logic                       sat_flag;
  logic                       accept;

  assign samp      = IN_BITS'(ob_to_signed(64'(i_LFSR_Data), IN_BITS));
  assign samp_ext  = SUM_W'(samp);
  assign accept    = i_Enable & i_LFSR_valid & ~i_Clear;
  assign prod_full = PROD_W'(sum_q) * PROD_W'($signed({1'b0, i_Gain}));

  noise_sat_add #(.IN_W(PROD_W), .OUT_W(OUT_BITS)) u_sat (
    .i_a  (prod_q),
    .i_b  (i_Offset),
    .o_y  (sat_y),
    .o_sat(sat_flag)
  );

  always_comb begin
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    sum_v_d = 1'b0;
    if (i_Clear) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (accept) begin
      if (cnt_q == CNT_MAX) begin
        sum_d   = acc_q + samp_ext;
        sum_v_d = 1'b1;
        acc_d   = '0;
        cnt_d   = '0;
      end else begin
        acc_d = acc_q + samp_ext;
        cnt_d = cnt_q + 1'b1;
      end
    end

    prod_d   = sum_v_q ? (prod_full >>> SHIFT) : prod_q;
    prod_v_d = sum_v_q & ~i_Clear;

    // A clear kills anything still in flight, including the final output stage.
    noise_d   = (prod_v_q & ~i_Clear) ? sat_y : noise_q;
    noise_v_d = prod_v_q & ~i_Clear;
    sat_d     = prod_v_q & ~i_Clear & sat_flag;
    sticky_d  = i_Clear ? 1'b0 : (sticky_q | (prod_v_q & sat_flag));
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      sum_q     <= '0;
      sum_v_q   <= 1'b0;
      prod_q    <= '0;
      prod_v_q  <= 1'b0;
      noise_q   <= '0;
      noise_v_q <= 1'b0;
      sat_q     <= 1'b0;
      sticky_q  <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      sum_q     <= sum_d;
      sum_v_q   <= sum_v_d;
      prod_q    <= prod_d;
      prod_v_q  <= prod_v_d;
      noise_q   <= noise_d;
      noise_v_q <= noise_v_d;
      sat_q     <= sat_d;
      sticky_q  <= sticky_d;
    end
  end

  assign o_Noise       = noise_q;
  assign o_Noise_valid = noise_v_q;
  assign o_Sat         = sat_q;
  assign o_Sat_sticky  = sticky_q;
  assign o_Count       = cnt_q;

endmodule

// File: tb/tb_lfsr_noise_shaper.sv
// Randomized bench for lfsr_noise_shaper against an integer block-sum reference model.
module tb_lfsr_noise_shaper;

  localparam int N = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic               en, vld, clr;
  logic [15:0]        data;
  logic [7:0]         gain;
  logic signed [15:0] offset;
  logic signed [15:0] noise;
  logic               noise_v, sat, sticky;
  logic [3:0]         count;

  lfsr_noise_shaper dut (
    .i_Clk        (clk),
    .i_Reset      (rst),
    .i_Enable     (en),
    .i_Clear      (clr),
    .i_LFSR_Data  (data),
    .i_LFSR_valid (vld),
    .i_Gain       (gain),
    .i_Offset     (offset),
    .o_Noise      (noise),
    .o_Noise_valid(noise_v),
    .o_Sat        (sat),
    .o_Sat_sticky (sticky),
    .o_Count      (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint due;
    longint val;
    bit     sat;
  } exp_t;

  exp_t   expq[$];
  int     n_tests = 0, n_fail = 0;
  longint cyc = 0;
  int     m_cnt = 0;
  longint m_acc = 0;
  bit     m_sticky = 0;
  int     pulses = 0;
  longint noise_sum = 0;
  int     noise_n = 0;
  logic [15:0] lfsr_st = 16'hACE1;

  task automatic check_eq(string tag, longint act, longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic longint floor_div(longint a, longint d);
    longint q;
    q = a / d;
    if ((a % d != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  // Block complete: sum -> scale by gain/1024 (gain/256 times 1/sqrt(16)) -> offset -> clamp.
  task automatic push_expect(longint total);
    exp_t   e;
    longint y;
    y     = floor_div(total * longint'(gain), 1024) + longint'(offset);
    e.sat = 1'b0;
    if (y > 32767) begin y = 32767; e.sat = 1'b1; end
    if (y < -32768) begin y = -32768; e.sat = 1'b1; end
    e.val = y;
    e.due = cyc + 2;
    expq.push_back(e);
  endtask

  task automatic step(bit e, bit v, logic [15:0] d, bit c);
    en = e; vld = v; data = d; clr = c;
    @(posedge clk);
    cyc++;
    if (c) begin
      m_cnt = 0; m_acc = 0; m_sticky = 0;
      expq.delete();
    end else if (e && v) begin
      m_acc += longint'(d) - 32768;
      m_cnt++;
      if (m_cnt == N) begin
        push_expect(m_acc);
        m_cnt = 0;
        m_acc = 0;
      end
    end
    #2;
    check_eq("count", longint'(count), longint'(m_cnt));
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0, 1'b0);
  endtask

  function automatic logic [15:0] lfsr_word();
    for (int i = 0; i < 16; i++)
      lfsr_st = lfsr_st[0] ? ((lfsr_st >> 1) ^ 16'hB400) : (lfsr_st >> 1);
    return lfsr_st;
  endfunction

  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst) begin
      if (noise_v) begin
        pulses++;
        noise_sum += longint'(noise);
        noise_n++;
        if (expq.size() == 0) begin
          check_eq("pulse_unexpected", longint'(noise_v), 0);
        end else begin
          e = expq.pop_front();
          if (e.sat) m_sticky = 1'b1;
          check_eq("pulse_cycle", cyc, e.due);
          check_eq("noise", longint'(noise), e.val);
          check_eq("sat", longint'(sat), longint'(e.sat));
          check_eq("sticky", longint'(sticky), longint'(m_sticky));
        end
      end else begin
        check_eq("sat_idle", longint'(sat), 0);
        if (expq.size() > 0 && expq[0].due <= cyc) begin
          check_eq("pulse_missing", longint'(noise_v), 1);
          void'(expq.pop_front());
        end
      end
    end
  end

  initial begin
    int  p0, acc_n, k;
    real sigma, bound, mean;

    rst = 1'b1; en = 0; vld = 0; clr = 0; data = 0; gain = 0; offset = 0;
    #3;
    check_eq("rst_noise", longint'(noise), 0);
    check_eq("rst_valid", longint'(noise_v), 0);
    check_eq("rst_sticky", longint'(sticky), 0);
    check_eq("rst_count", longint'(count), 0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;

    // Known-value block: 16 x 256, gain 255, offset -20 -> 1000
    gain = 8'd255; offset = -16'sd20; p0 = pulses;
    for (int i = 0; i < N; i++) step(1'b1, 1'b1, 16'h8100, 1'b0);
    idle(4);
    check_eq("t2_pulses", pulses - p0, 1);
    check_eq("t2_value", longint'(noise), 1000);
    check_eq("t2_sat", longint'(sticky), 0);

    // Positive then negative saturation
    gain = 8'd128; offset = 16'sd0;
    for (int i = 0; i < N; i++) step(1'b1, 1'b1, 16'hFFFF, 1'b0);
    idle(4);
    check_eq("t3_pos", longint'(noise), 32767);
    check_eq("t3_sticky", longint'(sticky), 1);
    gain = 8'd255;
    for (int i = 0; i < N; i++) step(1'b1, 1'b1, 16'h0000, 1'b0);
    idle(4);
    check_eq("t3_neg", longint'(noise), -32768);

    // Clear after 10 samples with sticky set
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 16'($urandom), 1'b0);
    step(1'b1, 1'b1, 16'($urandom), 1'b1);
    check_eq("t5_count", longint'(count), 0);
    check_eq("t5_sticky", longint'(sticky), 0);
    gain = 8'($urandom); offset = 16'($urandom_range(0, 2000)) - 16'sd1000;
    p0 = pulses;
    for (int i = 0; i < N - 1; i++) step(1'b1, 1'b1, 16'($urandom), 1'b0);
    idle(4);
    check_eq("t5_early", pulses - p0, 0);
    step(1'b1, 1'b1, 16'($urandom), 1'b0);
    idle(4);
    check_eq("t5_pulses", pulses - p0, 1);

    // Valid every third cycle, enable low for 20 cycles after sample 7
    gain = 8'($urandom); offset = 16'($urandom);
    p0 = pulses; acc_n = 0; k = 0;
    while (acc_n < N && k < 200) begin
      if (acc_n == 7) begin
        for (int i = 0; i < 20; i++) begin
          step(1'b0, (k % 3) == 0, 16'($urandom), 1'b0);
          k++;
        end
        check_eq("t4_hold", longint'(count), 7);
      end
      step(1'b1, (k % 3) == 0, 16'($urandom), 1'b0);
      if ((k % 3) == 0) acc_n++;
      k++;
    end
    idle(4);
    check_eq("t4_pulses", pulses - p0, 1);

    // Reset between the 16th sample and the output edge
    p0 = pulses;
    for (int i = 0; i < N; i++) step(1'b1, 1'b1, 16'($urandom), 1'b0);
    step(1'b0, 1'b0, 16'h0, 1'b0);
    rst = 1'b1;
    #1;
    check_eq("t1_noise", longint'(noise), 0);
    check_eq("t1_valid", longint'(noise_v), 0);
    check_eq("t1_sat", longint'(sat), 0);
    check_eq("t1_sticky", longint'(sticky), 0);
    expq.delete(); m_cnt = 0; m_acc = 0; m_sticky = 0;
    repeat (2) begin @(posedge clk); cyc++; end
    #2;
    rst = 1'b0;
    idle(4);
    check_eq("t1_pulses", pulses - p0, 0);
    check_eq("t1_count", longint'(count), 0);

    // Random phases with occasional clears
    for (int ph = 0; ph < 3; ph++) begin
      gain = 8'($urandom); offset = 16'($urandom);
      for (int i = 0; i < 300; i++)
        step($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 7, 16'($urandom),
             $urandom_range(0, 99) == 0);
      idle(4);
    end

    // LFSR-driven run: continuous valid, unity gain, no offset
    step(1'b0, 1'b0, 16'h0, 1'b1);
    gain = 8'd255; offset = 16'sd0;
    p0 = pulses; noise_sum = 0; noise_n = 0;
    for (int i = 0; i < 1000; i++) step(1'b1, 1'b1, lfsr_word(), 1'b0);
    idle(4);
    check_eq("t6_pulses", pulses - p0, 62);
    sigma = $sqrt(16.0 * 65536.0 * 65536.0 / 12.0) * 255.0 / 1024.0;
    bound = 3.0 * sigma / $sqrt(62.0);
    mean  = (noise_n > 0) ? real'(noise_sum) / real'(noise_n) : 1.0e9;
    check_eq("t6_mean_within_3sigma", longint'((mean < bound) && (mean > -bound)), 1);

    check_eq("queue_empty", longint'(expq.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
